moving_mean_unit: RTL and testbench

Parametrised streaming moving-average engine: accepts unsigned samples and outputs the mean of the most recent 2^LOG2_DEPTH samples once the window is full. A circular sample buffer and a running sum replace the fixed two-sample shift/add datapath, so the window size and data width are generic. The block sits between the sample source and the result register stage of the mean-computation datapath.

---
 rtl/moving_mean_unit.sv | 153 +++++++++++++++
 tb/tb_moving_mean_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/moving_mean_unit.sv
// moving_mean_unit: streaming moving average over the most recent
// 2^LOG2_DEPTH unsigned samples, built from a circular sample buffer and a
// running sum so window size and data width are generic.
//
// Ports:
//   clock        - single clock, rising edge
//   reset        - asynchronous, active-high; clears all state
//   clear        - synchronous window flush (same end state as reset)
//   in_valid     - data_in carries a sample this cycle (always accepted)
//   data_in      - unsigned sample, DATA_W bits
//   mean_valid   - one-cycle pulse, data_out holds a new mean
//   data_out     - current mean, holds between updates
//   window_full  - high once 2^LOG2_DEPTH samples accepted since reset/clear
//   sample_count - samples held, saturates at 2^LOG2_DEPTH
//
// Build option: define MEAN_ROUNDING_EN for round-half-up means; otherwise
// the mean is truncated toward zero. Timing is identical in both builds.
module moving_mean_unit #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     data_in,
  output logic                  mean_valid,
  output logic [DATA_W-1:0]     data_out,
  output logic                  window_full,
  output logic [LOG2_DEPTH:0]   sample_count
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned SUM_W = DATA_W + LOG2_DEPTH;
  localparam int unsigned CNT_W = LOG2_DEPTH + 1;
  localparam int unsigned PTR_W = LOG2_DEPTH;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               pend_q, pend_d;
  logic               mean_valid_q, mean_valid_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               full_q, full_d;

  logic [DATA_W-1:0]  buf_mem [DEPTH];
  logic [DATA_W-1:0]  oldest_c;
  logic               wr_en_c;
  logic [SUM_W-1:0]   sum_adj_c;

  // In RUN the slot about to be overwritten holds the sample leaving the window.
  assign oldest_c = buf_mem[ptr_q];

  // Optional half-LSB offset before the divide-by-shift; cannot overflow SUM_W.
`ifdef MEAN_ROUNDING_EN
  localparam logic [SUM_W-1:0] RND_OFS = SUM_W'(1) << (LOG2_DEPTH - 1);
  assign sum_adj_c = sum_q + RND_OFS;
`else
  assign sum_adj_c = sum_q;
`endif

  // Next-state, datapath and output logic.
  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    pend_d       = 1'b0;
    mean_valid_d = 1'b0;
    data_out_d   = data_out_q;
    full_d       = full_q;
    wr_en_c      = 1'b0;

    // pend_q marks that the previous edge accepted a sample in RUN, so
    // sum_q now includes it and the mean can be published.
    if (pend_q) begin
      mean_valid_d = 1'b1;
      data_out_d   = DATA_W'(sum_adj_c >> LOG2_DEPTH);
    end

    if (clear) begin
      state_d      = FILL;
      sum_d        = '0;
      cnt_d        = '0;
      ptr_d        = '0;
      mean_valid_d = 1'b0;
      data_out_d   = '0;
      full_d       = 1'b0;
    end else if (in_valid) begin
      wr_en_c = 1'b1;
      ptr_d   = ptr_q + PTR_W'(1);
      case (state_q)
        FILL: begin
          sum_d = sum_q + SUM_W'(data_in);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DEPTH - 1)) begin
            state_d = RUN;
            full_d  = 1'b1;
            pend_d  = 1'b1;
          end
        end
        RUN: begin
          // Exact: oldest_c was added to the sum when it entered the window.
          sum_d  = sum_q + SUM_W'(data_in) - SUM_W'(oldest_c);
          pend_d = 1'b1;
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= FILL;
      sum_q        <= '0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      pend_q       <= 1'b0;
      mean_valid_q <= 1'b0;
      data_out_q   <= '0;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      pend_q       <= pend_d;
      mean_valid_q <= mean_valid_d;
      data_out_q   <= data_out_d;
      full_q       <= full_d;
    end
  end

  // Sample buffer; stale contents are never read while filling.
  always_ff @(posedge clock) begin
    if (wr_en_c) begin
      buf_mem[ptr_q] <= data_in;
    end
  end

  assign mean_valid   = mean_valid_q;
  assign data_out     = data_out_q;
  assign window_full  = full_q;
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_moving_mean_unit.sv
// Scoreboard bench for moving_mean_unit (DATA_W=16, window of 4).
module tb_moving_mean_unit;

`ifdef MEAN_ROUNDING_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [15:0] data_in;
  logic        mean_valid;
  logic [15:0] data_out;
  logic        window_full;
  logic [2:0]  sample_count;

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  moving_mean_unit #(
    .DATA_W     (16),
    .LOG2_DEPTH (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .mean_valid   (mean_valid),
    .data_out     (data_out),
    .window_full  (window_full),
    .sample_count (sample_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every mean_valid pulse must match the oldest expected mean,
  // arriving exactly one edge after the accepting edge.
  always @(negedge clock) begin
    if (!reset && mean_valid) begin
      if (q.size() == 0) begin
        check("unexpected mean_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("mean value", int'(data_out), int'(e.val));
        check("mean latency", cyc, e.due);
      end
    end
  end

  // Drive one sample (optionally with clear) and check the count/full flags
  // right after the accepting edge. Expected mean is queued when push is set.
  task automatic put(input logic [15:0] d, input logic clr, input bit push,
                     input logic [15:0] e, input int cnt, input bit full);
    exp_t x;
    @(negedge clock);
    if (push) begin
      x.val = e;
      x.due = cyc + 2;
      q.push_back(x);
    end
    in_valid = 1'b1;
    data_in  = d;
    clear    = clr;
    @(posedge clock);
    #1;
    check("sample_count", int'(sample_count), cnt);
    check("window_full", int'(window_full), int'(full));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0;
      clear    = 1'b0;
    end
  endtask

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset data_out", int'(data_out), 0);
    check("reset mean_valid", int'(mean_valid), 0);
    check("reset window_full", int'(window_full), 0);
    check("reset sample_count", int'(sample_count), 0);
    @(negedge clock);
    reset = 1'b0;

    // Fill then slide (wr_ptr wraps on the 5th sample).
    put(16'd10, 1'b0, 1'b0, 16'd0,  1, 1'b0);
    put(16'd20, 1'b0, 1'b0, 16'd0,  2, 1'b0);
    put(16'd30, 1'b0, 1'b0, 16'd0,  3, 1'b0);
    put(16'd40, 1'b0, 1'b1, 16'd25, 4, 1'b1);
    put(16'd50, 1'b0, 1'b1, 16'd35, 4, 1'b1);
    put(16'd60, 1'b0, 1'b1, 16'd45, 4, 1'b1);
    idle(2);

    // Rounding: sum 7 -> 1 truncated, 2 rounded.
    put(16'd0, 1'b1, 1'b0, 16'd0, 0, 1'b0);
    check("clear data_out", int'(data_out), 0);
    put(16'd1, 1'b0, 1'b0, 16'd0, 1, 1'b0);
    put(16'd2, 1'b0, 1'b0, 16'd0, 2, 1'b0);
    put(16'd2, 1'b0, 1'b0, 16'd0, 3, 1'b0);
    put(16'd2, 1'b0, 1'b1, ROUND ? 16'd2 : 16'd1, 4, 1'b1);
    idle(2);

    // Full-scale samples: no sum overflow.
    put(16'd0, 1'b1, 1'b0, 16'd0, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      put(16'hFFFF, 1'b0, i == 3, 16'hFFFF, i + 1, i == 3);
    idle(2);

    // Sparse samples in RUN, then clear wins over a simultaneous sample.
    // (3*65535+10)/4 = 49153.75 ; (2*65535+30)/4 = 32775
    put(16'd10, 1'b0, 1'b1, ROUND ? 16'd49154 : 16'd49153, 4, 1'b1);
    idle(2);
    put(16'd20, 1'b0, 1'b1, 16'd32775, 4, 1'b1);
    idle(2);
    put(16'd99, 1'b1, 1'b0, 16'd0, 0, 1'b0);
    check("clear+valid data_out", int'(data_out), 0);
    check("clear+valid mean_valid", int'(mean_valid), 0);
    put(16'd4, 1'b0, 1'b0, 16'd0, 1, 1'b0);
    put(16'd4, 1'b0, 1'b0, 16'd0, 2, 1'b0);
    put(16'd4, 1'b0, 1'b0, 16'd0, 3, 1'b0);
    put(16'd4, 1'b0, 1'b1, 16'd4, 4, 1'b1);
    idle(3);

    // Async reset between edges, with a mean still pending (must be lost).
    put(16'd100, 1'b0, 1'b0, 16'd0, 4, 1'b1);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("async reset data_out", int'(data_out), 0);
    check("async reset mean_valid", int'(mean_valid), 0);
    check("async reset window_full", int'(window_full), 0);
    check("async reset sample_count", int'(sample_count), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    put(16'd8, 1'b0, 1'b0, 16'd0, 1, 1'b0);
    put(16'd8, 1'b0, 1'b0, 16'd0, 2, 1'b0);
    put(16'd8, 1'b0, 1'b0, 16'd0, 3, 1'b0);
    put(16'd8, 1'b0, 1'b1, 16'd8, 4, 1'b1);
    idle(3);

    check("scoreboard drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
